// File: rtl/cache_define.sv
// Shared cache geometry, eviction FSM state encoding and miss-capture payload
// for the last-level-cache eviction controller.
package cache_define;

  localparam int unsigned WAYS        = 8;
  localparam int unsigned WAY_BITS    = $clog2(WAYS);
  localparam int unsigned TAG_BITS    = 12;
  localparam int unsigned INDEX_BITS  = 8;
  localparam int unsigned OFFSET_BITS = 6;
  localparam int unsigned ADDR_BITS   = TAG_BITS + INDEX_BITS + OFFSET_BITS;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_DONE      = 3'd4
  } evict_state_e;

  // Everything latched from the miss/victim inputs at accept time
  typedef struct packed {
    logic [TAG_BITS-1:0]   miss_tag;
    logic [INDEX_BITS-1:0] index;
    logic [WAY_BITS-1:0]   way;
    logic                  line_valid;
    logic                  dirty;
    logic [TAG_BITS-1:0]   victim_tag;
  } miss_req_t;

  // Line-aligned address: {tag, index, zero offset}
  function automatic logic [ADDR_BITS-1:0] line_addr(
    input logic [TAG_BITS-1:0]   tag,
    input logic [INDEX_BITS-1:0] index
  );
    return {tag, index, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_evict_ctrl.sv
// LLC miss eviction sequencer: captures a miss with its PLRU victim, writes
// back a dirty valid victim, issues the line fill, then pulses done.
module llc_evict_ctrl
  import cache_define::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [INDEX_BITS-1:0] miss_index,
  input  logic [TAG_BITS-1:0]   miss_tag,
  input  logic [WAY_BITS-1:0]   victim_way,
  input  logic                  victim_line_valid,
  input  logic                  victim_dirty,
  input  logic [TAG_BITS-1:0]   victim_tag,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_BITS-1:0]  wb_addr,
  output logic                  fill_valid,
  input  logic                  fill_ready,
  output logic [ADDR_BITS-1:0]  fill_addr,
  output logic [WAY_BITS-1:0]   fill_way,
  output logic                  done,
  output logic [CNT_W-1:0]      evict_cnt,
  output logic [CNT_W-1:0]      wb_cnt
);

  evict_state_e          r_state;
  miss_req_t             r_req;
  logic                  r_miss_ready;
  logic                  r_wb_valid;
  logic [ADDR_BITS-1:0]  r_wb_addr;
  logic                  r_fill_valid;
  logic [ADDR_BITS-1:0]  r_fill_addr;
  logic [WAY_BITS-1:0]   r_fill_way;
  logic                  r_done;
  logic [CNT_W-1:0]      r_evict_cnt;
  logic [CNT_W-1:0]      r_wb_cnt;

  logic                  w_accept;
  logic                  w_needs_wb;

  // Performance counters hold at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept   = miss_valid && r_miss_ready;
  // An invalid victim is never written back, whatever its dirty bit says
  assign w_needs_wb = r_req.line_valid && r_req.dirty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_miss_ready <= 1'b1;
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_way   <= '0;
      r_done       <= 1'b0;
      r_evict_cnt  <= '0;
      r_wb_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req.miss_tag   <= miss_tag;
            r_req.index      <= miss_index;
            r_req.way        <= victim_way;
            r_req.line_valid <= victim_line_valid;
            r_req.dirty      <= victim_dirty;
            r_req.victim_tag <= victim_tag;
            r_miss_ready     <= 1'b0;
            r_state          <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_req.line_valid) begin
            r_evict_cnt <= sat_inc(r_evict_cnt);
          end
          if (w_needs_wb) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= line_addr(r_req.victim_tag, r_req.index);
            r_state    <= ST_WRITEBACK;
          end else begin
            r_fill_valid <= 1'b1;
            r_fill_addr  <= line_addr(r_req.miss_tag, r_req.index);
            r_fill_way   <= r_req.way;
            r_state      <= ST_FILL;
          end
        end
        ST_WRITEBACK: begin
          if (wb_ready) begin
            r_wb_cnt     <= sat_inc(r_wb_cnt);
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= '0;
            r_fill_valid <= 1'b1;
            r_fill_addr  <= line_addr(r_req.miss_tag, r_req.index);
            r_fill_way   <= r_req.way;
            r_state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_ready) begin
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_way   <= '0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done       <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_wb_valid   <= 1'b0;
          r_wb_addr    <= '0;
          r_fill_valid <= 1'b0;
          r_fill_addr  <= '0;
          r_fill_way   <= '0;
          r_done       <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign miss_ready = r_miss_ready;
  assign wb_valid   = r_wb_valid;
  assign wb_addr    = r_wb_addr;
  assign fill_valid = r_fill_valid;
  assign fill_addr  = r_fill_addr;
  assign fill_way   = r_fill_way;
  assign done       = r_done;
  assign evict_cnt  = r_evict_cnt;
  assign wb_cnt     = r_wb_cnt;

endmodule

// File: doc/llc_evict_ctrl.md
LLC_EVICT_CTRL -- requirements
Module: llc_evict_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the eviction and writeback performance counters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 miss_valid  input  1  miss request with victim information present.
REQ-005 miss_ready  output  1  block can accept a miss request.
REQ-006 miss_index  input  INDEX_BITS  set index of the missing line.
REQ-007 miss_tag  input  TAG_BITS  tag of the missing line.
REQ-008 victim_way  input  WAY_BITS  way chosen by PLRU victim selection.
REQ-009 victim_line_valid  input  1  victim way currently holds a valid line.
REQ-010 victim_dirty  input  1  victim line is in Modified state.
REQ-011 victim_tag  input  TAG_BITS  tag stored in the victim way.
REQ-012 wb_valid / wb_ready  output / input  1 / 1  writeback request handshake toward next-level memory.
REQ-013 wb_addr  output  ADDR_BITS  line address being written back.
REQ-014 fill_valid / fill_ready  output / input  1 / 1  fill request handshake.
REQ-015 fill_addr  output  ADDR_BITS  line address to fetch.
REQ-016 fill_way  output  WAY_BITS  way to install the fetched line into.
REQ-017 done  output  1  one-cycle pulse on completion of the eviction/fill sequence.
REQ-018 evict_cnt / wb_cnt  output  CNT_W each  count of valid-line evictions / completed writebacks.

Function
REQ-019 The FSM SHALL have states IDLE, CHECK, WRITEBACK, FILL, DONE.
REQ-020 miss_ready SHALL be 1 only in IDLE; a request is accepted when miss_valid & miss_ready, capturing all miss_* and victim_* inputs; next state CHECK.
REQ-021 miss_valid outside IDLE SHALL be ignored, with no state or counter change.
REQ-022 CHECK SHALL last exactly one cycle: next state WRITEBACK if captured valid & dirty, else FILL.
REQ-023 In CHECK, evict_cnt SHALL increment when captured victim_line_valid = 1, regardless of dirty.
REQ-024 WRITEBACK: wb_valid = 1, wb_addr = {victim_tag, miss_index, OFFSET_BITS zeros}; on wb_ready, wb_cnt increments and next state is FILL.
REQ-025 FILL: fill_valid = 1, fill_addr = {miss_tag, miss_index, OFFSET_BITS zeros}, fill_way = captured victim_way; on fill_ready, next state is DONE.
REQ-026 wb_valid / fill_valid SHALL stay high, with address and way stable, until the matching ready is sampled high; they SHALL never deassert without a handshake.
REQ-027 DONE: done = 1 for exactly one cycle; next state IDLE.
REQ-028 Minimum latency, accept at cycle N: clean victim -> fill_valid at N+2, done at N+3 (ready held high), miss_ready again at N+4; dirty victim -> wb_valid at N+2, fill_valid at N+3, done at N+4.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 An invalid victim with dirty = 1 SHALL be treated as clean: no writeback, no count.
REQ-031 wb_addr / fill_addr / fill_way SHALL read 0 when the corresponding valid is low.

Reset
REQ-032 On rst, the next edge SHALL force IDLE, with miss_ready = 1 afterwards and wb_valid = fill_valid = done = 0, all address/way outputs = 0, and evict_cnt = wb_cnt = 0.
REQ-033 rst mid-sequence, including during a stalled wb or fill, SHALL abandon the request with no done pulse.

Structure
REQ-034 WAYS, WAY_BITS = $clog2(WAYS), TAG_BITS, INDEX_BITS, OFFSET_BITS and ADDR_BITS SHALL live in cache_define; the FSM state enum SHALL also live in cache_define.
REQ-035 Implementation SHALL be one module with no sub-modules; the saturating counter MAY be a local function.

Verification
REQ-036 Clean valid victim, way 5, tag 0x0A3, index 0x12, fill_ready high -> no wb_valid, fill_addr = {0x0A3, 0x12, 0}, fill_way = 5, done at N+3, evict_cnt = 1, wb_cnt = 0.
REQ-037 Dirty victim tag 0x7FF, wb_ready held low 10 cycles -> wb_valid and wb_addr stable for 10 cycles, then fill; wb_cnt = 1, done at N+14.
REQ-038 Invalid victim with dirty = 1 -> straight to FILL, evict_cnt and wb_cnt unchanged.
REQ-039 miss_valid held high through a dirty sequence -> exactly one capture; second accept only when miss_ready returns at N+5 (ready held high).
REQ-040 rst asserted in FILL with fill_ready low -> next cycle fill_valid = 0, miss_ready = 1, counters 0, no done.
REQ-041 Force evict_cnt to all-ones, then one more valid eviction -> evict_cnt stays all-ones.
